// File: rtl/spi_device_byte.sv
// SPI mode-0 target: synchronizes SCK/CSB/MOSI into clk_i, deserialises received bytes
// and shifts a one-entry transmit holding register out on MISO, MSB first.
module spi_device_byte #(
  parameter int unsigned SyncStages  = 2,
  parameter logic [7:0]  DefaultByte = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sck_i,
  input  logic       csb_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  localparam int unsigned ByteW = 8;
  localparam int unsigned CntW  = 3;

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                state_q, state_d;
  logic [SyncStages-1:0] sck_sync_q, sck_sync_d;
  logic [SyncStages-1:0] csb_sync_q, csb_sync_d;
  logic [SyncStages-1:0] mosi_sync_q, mosi_sync_d;
  logic                  sck_d_q;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [ByteW-1:0]      rx_sr_q, rx_sr_d;
  logic [ByteW-1:0]      tx_sr_q, tx_sr_d;
  logic [ByteW-1:0]      hold_q, hold_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [ByteW-1:0]      rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;
  logic                  busy_q, busy_d;

  logic             sck_s, csb_s, mosi_s;
  logic             rise_c, fall_c, active_c;
  logic [ByteW-1:0] next_byte_c;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SyncStages-2:0], sck_i};
    csb_sync_d  = {csb_sync_q[SyncStages-2:0], csb_i};
    mosi_sync_d = {mosi_sync_q[SyncStages-2:0], mosi_i};
    sck_s       = sck_sync_q[SyncStages-1];
    csb_s       = csb_sync_q[SyncStages-1];
    mosi_s      = mosi_sync_q[SyncStages-1];
    rise_c      = sck_s & ~sck_d_q;
    fall_c      = ~sck_s & sck_d_q;
    active_c    = (state_q == ACTIVE) & ~csb_s;
    next_byte_c = tx_ready_q ? DefaultByte : hold_q;

    state_d    = csb_s ? IDLE : ACTIVE;
    busy_d     = ~csb_s;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;

    if (!active_c) begin
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else begin
      miso_oe_d = 1'b1;
      if (rise_c) begin
        rx_sr_d   = {rx_sr_q[ByteW-2:0], mosi_s};
        bit_cnt_d = bit_cnt_q + CntW'(1);
        if (bit_cnt_q == CntW'(7)) begin
          rx_data_d  = rx_sr_d;
          rx_valid_d = 1'b1;
        end
      end
      // At a byte boundary MISO only peeks; the byte is consumed on the first rise.
      if (bit_cnt_q == '0) begin
        miso_d = next_byte_c[ByteW-1];
        if (rise_c) begin
          tx_sr_d    = next_byte_c;
          underrun_d = tx_ready_q;
        end
      end else if (fall_c) begin
        tx_sr_d = {tx_sr_q[ByteW-2:0], 1'b0};
        miso_d  = tx_sr_q[ByteW-2];
      end
    end

    // A write coinciding with a consume fills the register for the following byte.
    if (tx_valid_i && tx_ready_q) begin
      hold_d     = tx_data_i;
      tx_ready_d = 1'b0;
    end else if (active_c && rise_c && (bit_cnt_q == '0)) begin
      tx_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      csb_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_d_q     <= 1'b0;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      hold_q      <= '0;
      tx_ready_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      csb_sync_q  <= csb_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_d_q     <= sck_s;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      hold_q      <= hold_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      busy_q      <= busy_d;
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = miso_oe_q;
  assign tx_ready_o    = tx_ready_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;
  assign busy_o        = busy_q;

endmodule

// File: doc/spi_device_byte.md
Name: spi_device_byte

Overview:
- SPI target (slave) endpoint; the counterpart to the team's spi_host. Mode 0 only (CPOL=0, CPHA=0), MSB first, one chip-select.
- Oversamples SCK/CSB/MOSI in the clk_i domain through synchronizers, then deserialises received bytes into a valid pulse.
- Serialises transmit bytes from a one-entry holding register onto MISO, which allows loopback and board-level testing of the UART-to-SPI bridge.

Parameters:
- SyncStages, 2, synchronizer depth for sck_i/csb_i/mosi_i (min 2).
- DefaultByte, 8'hFF, byte sent when the holding register is empty at a byte start.

Ports:
- clk_i  in  1  system clock; must be >= 8x SCK frequency.
- rst_ni  in  1  reset, asynchronous, active-low.
- sck_i  in  1  SPI clock from host, asynchronous.
- csb_i  in  1  chip select, active-low, asynchronous.
- mosi_i  in  1  host-to-device data.
- miso_o  out  1  device-to-host data (registered).
- miso_oe_o  out  1  MISO pad output enable; 1 only while CSB is active.
- tx_data_i  in  8  byte to transmit.
- tx_valid_i  in  1  tx_data_i valid; accepted when tx_valid_i & tx_ready_o.
- tx_ready_o  out  1  holding register empty.
- rx_data_o  out  8  last complete received byte; held until the next update.
- rx_valid_o  out  1  one-cycle pulse when rx_data_o updates.
- tx_underrun_o  out  1  one-cycle pulse when DefaultByte is consumed because the holding register was empty.
- busy_o  out  1  synchronized CSB active.

Behaviour:
- Reset values: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, busy_o=0, bit_cnt=0, holding register empty. Synchronizer flops reset to idle: sck=0, csb=1, mosi=0.
- Synchronization and edge detect:
  - sck_s, csb_s and mosi_s pass through SyncStages flops.
  - rise = sck_s & ~sck_d; fall = ~sck_s & sck_d.
  - Edges are ignored while csb_s=1.
- State machine:
  - IDLE (csb_s=1): bit_cnt=0, miso_oe_o=0, miso_o=0.
  - IDLE -> ACTIVE when csb_s=0.
  - ACTIVE -> IDLE when csb_s=1, from any bit_cnt.
- Byte start (bit_cnt==0, ACTIVE):
  - miso_o = next_byte[7], where next_byte = holding full ? hold_q : DefaultByte. This is a peek only; nothing is consumed.
  - On rise with bit_cnt==0: tx_sr <= next_byte; holding register cleared; tx_underrun_o pulses next cycle if the register was empty; bit_cnt <= 1.
- Mid-byte:
  - On rise, rx_sr <= {rx_sr[6:0], mosi_s}; bit_cnt increments (3-bit, wraps 7->0).
  - On fall with bit_cnt!=0, tx_sr shifts left and miso_o <= new tx_sr[7].
- Byte complete:
  - On the 8th rise (bit_cnt 7->0), rx_data_o <= {rx_sr[6:0], mosi_s} and rx_valid_o=1 the following cycle.
  - There is no backpressure; the consumer must take the byte within 8 SCK periods.
- The fall after the 8th rise returns to the byte-start peek. No byte is consumed unless a further rise occurs, so the trailing SCK fall before CSB rises loses no data.
- TX handshake:
  - tx_ready_o = ~hold_full, registered.
  - A write accepted in the same cycle as a consume is not bypassed. It fills the holding register for the next byte; the current byte uses whatever was there, or DefaultByte.
  - Firmware must write before CSB falls. A write landing within SyncStages+1 cycles of the first rise may change MISO late; this is a legal but undefined data race.
- CSB rising mid-byte: the partial rx byte is discarded with no rx_valid_o. A tx byte already consumed is lost, and the holding register is unaffected. bit_cnt=0.
- CSB falling again: restarts at byte start.
- Async reset mid-transfer returns all state to reset values immediately.
- Latency: MISO/MOSI respond 3 to SyncStages+2 clk_i cycles after an SCK edge. Each SCK half-period must be at least 4 clk_i cycles.

Test Plan:
- Preload tx 8'hA5, CSB low, host clocks MOSI 8'h3C at clk/8 -> host receives 8'hA5; rx_data_o=8'h3C with a single rx_valid_o pulse; tx_ready_o back to 1; no underrun.
- Empty holding register, 1-byte transfer, MOSI 8'h00 -> MISO carries 8'hFF; tx_underrun_o pulses exactly once; rx_data_o=8'h00.
- 3-byte burst, CSB held, tx written 8'h11/8'h22/8'h33 each as tx_ready_o rises, MOSI 8'h01/8'h02/8'h03 -> host reads 11,22,33; three rx_valid_o pulses with matching data.
- CSB raised after 4 SCK bits -> no rx_valid_o; next full transfer with MOSI 8'hC3 yields rx_data_o=8'hC3 (no stale bits); holding register state per the consume rule.
- Preload 8'h5A, end transfer normally after 1 byte with a tx byte 8'h77 waiting -> 8'h77 still held (tx_ready_o=0) and sent first in the next transaction.
- rst_ni asserted mid-byte -> all outputs at reset values within the same cycle; the subsequent transfer is correct.
